// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state encoding shared by the multicycle ALU
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_LUI   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic             div_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] opb;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    // {acc,q} is the product shift pair for MULTU and the remainder/quotient pair for DIVU;
    // a zero divisor naturally yields quotient all ones and remainder = dividend.
    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, opb};
        ge      = ~diff[WIDTH];
        if (div_mode) begin
            nxt_hi = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            nxt_lo = {q[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], q[WIDTH-1:1]};
        end
    end

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_mode <= 1'b0;
            acc      <= '0;
            q        <= '0;
            opb      <= '0;
            cnt      <= '0;
        end else if (load) begin
            div_mode <= (op == OP_DIVU);
            acc      <= '0;
            q        <= a;
            opb      <= b;
            cnt      <= '0;
        end else if (step) begin
            acc      <= nxt_hi;
            q        <= nxt_lo;
            cnt      <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU with single-cycle logic ops and iterative MULTU/DIVU
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state;
    state_e           state_nxt;
    logic             accept;
    logic             load_iter;
    logic             step_iter;
    logic             fin_iter;
    logic             iter_last;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] alu_out;

    always_comb begin
        alu_out = '0;
        case (ctrl)
            OP_AND:  alu_out = rs & rt;
            OP_OR:   alu_out = rs | rt;
            OP_ADD:  alu_out = rs + rt;
            OP_XOR:  alu_out = rs ^ rt;
            OP_LUI:  alu_out = {rt[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SUB:  alu_out = rs - rt;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (rs < rt)};
            OP_NOR:  alu_out = ~(rs | rt);
            OP_MFHI: alu_out = hi;
            OP_MFLO: alu_out = lo;
            default: alu_out = '0;
        endcase
    end

    // FIN doubles as an issue slot so a new op can follow a done pulse with no gap.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step_iter = 1'b0;
        fin_iter  = 1'b0;
        busy      = (state != ST_IDLE);
        done      = (state == ST_FIN);
        case (state)
            ST_IDLE, ST_FIN: begin
                state_nxt = ST_IDLE;
                if (start) begin
                    accept = 1'b1;
                    if (ctrl == OP_MULTU)
                        state_nxt = ST_MUL;
                    else if (ctrl == OP_DIVU)
                        state_nxt = ST_DIV;
                    else
                        state_nxt = ST_FIN;
                end
            end
            ST_MUL, ST_DIV: begin
                step_iter = 1'b1;
                if (iter_last) begin
                    fin_iter  = 1'b1;
                    state_nxt = ST_FIN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign load_iter = accept && is_iterative(ctrl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
            hi     <= '0;
            lo     <= '0;
        end else if (fin_iter) begin
            hi     <= iter_hi;
            lo     <= iter_lo;
            result <= iter_lo;
            zero   <= (iter_lo == '0);
        end else if (accept && !is_iterative(ctrl)) begin
            result <= alu_out;
            zero   <= (alu_out == '0);
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_iter),
        .op     (ctrl),
        .a      (rs),
        .b      (rt),
        .step   (step_iter),
        .nxt_hi (iter_hi),
        .nxt_lo (iter_lo),
        .last   (iter_last)
    );

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width; legal values are even and >= 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to launch the operation on ctrl/rs/rt.
REQ-005 SHALL have port ctrl, input, 4 bits: operation code per REQ-012.
REQ-006 SHALL have ports rs and rt, input, WIDTH bits each: operand A and operand B (rt also carries the immediate).
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when result, zero, hi and lo are valid.
REQ-009 SHALL have port result, output, WIDTH bits: registered operation result.
REQ-010 SHALL have port zero, output, 1 bit: registered flag, result == 0.
REQ-011 SHALL have ports hi and lo, output, WIDTH bits each: multiply/divide result registers.

Function
REQ-012 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 LUI, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1100 NOR, 1001 MULTU, 1010 DIVU, 1101 MFHI, 1110 MFLO; every other code yields result 0 with normal single-op timing.
REQ-013 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow output.
REQ-014 LUI SHALL produce {rt[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-015 SLT/SLTU SHALL produce 1 or 0, zero-extended to WIDTH.
REQ-016 FSM states SHALL be IDLE, MUL, DIV, FIN; a start seen in IDLE latches ctrl, rs and rt.
REQ-017 Single-cycle ops (all codes except MULTU/DIVU) SHALL go IDLE->FIN: start in cycle n gives done and result in cycle n+1; busy is high in cycle n+1 only.
REQ-018 MULTU SHALL be shift-add over exactly WIDTH iterations (IDLE->MUL->FIN): done in cycle n+WIDTH+1; {hi,lo} = full 2*WIDTH-bit unsigned product; result = lo.
REQ-019 DIVU SHALL be restoring division over exactly WIDTH iterations (IDLE->DIV->FIN), same latency: lo = quotient, hi = remainder, result = lo.
REQ-020 DIVU with rt == 0 SHALL take the same latency and give lo = all ones, hi = rs, result = all ones.
REQ-021 MFHI/MFLO SHALL return hi/lo as they stood at start.
REQ-022 hi and lo SHALL change only on MULTU/DIVU completion.
REQ-023 FIN SHALL last one cycle, assert done, then return to IDLE; a start in the FIN cycle SHALL be accepted (back-to-back issue).
REQ-024 start while in MUL or DIV SHALL be ignored, with no effect on state or outputs.
REQ-025 result and zero SHALL hold their value between done pulses.
REQ-026 busy SHALL be high in every cycle where state is not IDLE.

Reset
REQ-027 While rst_n is low, state SHALL be IDLE and busy, done, result, hi and lo SHALL be 0; zero SHALL be 1.
REQ-028 Reset asserted during MUL/DIV SHALL abort the operation with no done pulse and no hi/lo update.

Structure
REQ-029 Opcode constants and the FSM state encoding SHALL live in shared package alu_pkg, which the datapath control unit also uses.
REQ-030 The iterative multiply/divide datapath (accumulator, shift registers, iteration counter of clog2(WIDTH)+1 bits) SHALL be a single sub-module, muldiv_iter; the logic ops stay in alu_multicycle.

Verification
REQ-031 WIDTH=32, ADD rs=0xFFFFFFFF rt=1 -> done at n+1, result 0, zero 1.
REQ-032 WIDTH=32, SLT rs=0xFFFFFFFE rt=1 -> result 1; SLTU with the same operands -> result 0.
REQ-033 WIDTH=32, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at n+33, hi 0xFFFFFFFE, lo 0x00000001; an extra start at n+5 is ignored.
REQ-034 WIDTH=8, DIVU 200/7 -> done at n+9, lo 28, hi 4; DIVU 5/0 -> lo 0xFF, hi 5.
REQ-035 WIDTH=32, MULTU started, rst_n pulsed low at n+10 -> busy 0, no done, hi/lo 0; new ADD 2+3 then gives 5 at the next cycle.
REQ-036 WIDTH=32, LUI rt=0x1234 issued in the FIN cycle of a DIVU, then MFHI -> results 0x12340000 then the DIVU remainder, on consecutive done pulses.
